pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. It sequences every pipeline register (if_id, id_ex, ex_mem, mem_wb) and the PC through per-stage stall and flush vectors. It resolves five hazard sources:
- load-use data hazards
- instruction-fetch bus wait
- multi-cycle divide occupancy
- data-bus wait
- MEM-stage exceptions

Stall bit i freezes stage i. The register directly downstream of the frozen region receives a bubble through its flush bit.

## Interface
Parameters:
- DIV_CYCLES, 32: EX cycles a divide occupies after `ex_div_start`; legal range 2..63.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_wd  in  5  destination register of the EX instruction
- ex_div_start  in  1  divide issues in EX this cycle
- div_done  out  1  one-cycle pulse telling EX the divide result is valid
- if_req, if_ack  in  1 each  instruction-bus request / acknowledge
- mem_req, mem_ack  in  1 each  data-bus request from MEM / acknowledge
- mem_abort  out  1  one-cycle pulse cancelling an outstanding data request
- mem_excp  in  1  exception committed by the MEM-stage instruction
- excp_target  in  32  handler address
- stall  out  5  [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb
- flush  out  5  same indexing; [0] is always 0
- pc_redirect  out  1  PC loads redirect_pc next edge
- redirect_pc  out  32  redirect address

## Operation
- FSM states: RUN, DIV_WAIT, DMEM_WAIT. `div_cnt` is 6 bits.
- Priority, highest first, evaluated every cycle: rst > mem_excp > dmem wait > div wait > load-use > imem wait.
- **rst**: next state RUN, `div_cnt` 0.
  - Outputs while rst is high: stall=0, flush=5'b11110, pc_redirect=0, redirect_pc=0, div_done=0, mem_abort=0.
- **mem_excp** (any state):
  - flush=5'b11110, stall=0, pc_redirect=1, redirect_pc=excp_target.
  - Next state RUN, `div_cnt` cleared.
  - mem_abort=1 if in DMEM_WAIT or if (mem_req && !mem_ack) this cycle.
- **Data-bus wait**: mem_req && !mem_ack in RUN or DIV_WAIT.
  - Enter/stay in DMEM_WAIT.
  - stall=5'b01111, flush=5'b10000.
  - `div_cnt` keeps counting, so a divide in flight completes in the background.
  - The div_done pulse, if due, is held until DMEM_WAIT exits.
  - On the mem_ack cycle: stall=0. Next state is DIV_WAIT if `div_cnt`≠0, else RUN.
- **ex_div_start** in RUN:
  - Next state DIV_WAIT, `div_cnt`=DIV_CYCLES-1.
  - stall=5'b00111, flush=5'b01000, starting that same cycle.
- **DIV_WAIT**:
  - stall=5'b00111, flush=5'b01000. `div_cnt` decrements.
  - When `div_cnt`==1: div_done=1 and stall=0 that cycle; next state RUN.
- **Load-use** (RUN only): ex_mem_read && ex_wd≠0 && ((id_uses_rs && id_rs==ex_wd) || (id_uses_rt && id_rt==ex_wd)).
  - stall=5'b00011, flush=5'b00100. Resolves in one cycle.
- **Imem wait** (RUN only): if_req && !if_ack.
  - stall=5'b00001, flush=5'b00010.
- **Otherwise**: stall=0, flush=0.
- Outputs are combinational from state and inputs. Only state, `div_cnt` and the held-div_done flag are registered.
- Invariant: stall is always a contiguous low-order run (0, 1, 3, 7, 15).

## Timing
- Zero-cycle response: a hazard input asserted in cycle N drives stall/flush in cycle N.
- Divide: ex_div_start at cycle N gives div_done at N+DIV_CYCLES-1, absent data-bus waits. The pipeline advances at the edge ending that cycle.
- Overlapping waits: total freeze equals the union of both waits, not the sum.
- mem_ack in the same cycle as mem_req: no stall, no state change.
- mem_excp in the same cycle as ex_div_start: exception wins and the divide is discarded.
- rst asserted mid-DIV_WAIT or mid-DMEM_WAIT: state returns to RUN at the next edge, with no div_done or mem_abort pulse.

## Structure
- Package `pipe_ctrl_pkg`:
  - stage index constants (STG_PC..STG_WB)
  - state encoding
  - the five stall masks and matching flush masks
- Sub-module `hazard_detect`: the combinational load-use comparator, with outputs luse.
- Everything else is flat in pipe_ctrl.

## Test plan
1. Load-use: ex_mem_read=1, ex_wd=5, id_rs=5, id_uses_rs=1 -> stall=00011, flush=00100 for exactly one cycle. With ex_wd=0 there is no stall.
2. Divide, DIV_CYCLES=32: ex_div_start pulse at cycle 10 -> stall=00111 during cycles 10..40, div_done=1 and stall=0 at cycle 41.
3. Data wait during divide: mem_req held high from cycle 15, mem_ack at cycle 20 -> stall=01111 during cycles 15..19, then DIV_WAIT resumes. div_done still occurs at cycle 41.
4. Data wait covering divide completion: mem_ack delayed to cycle 45 -> div_done is held and pulses on the cycle-45 exit.
5. Exception in DMEM_WAIT: mem_excp=1, excp_target=32'hBFC00380 -> flush=11110, pc_redirect=1, redirect_pc=BFC00380, mem_abort=1. State is RUN next cycle.
6. rst high for 2 cycles mid-DIV_WAIT -> flush=11110, stall=0 during reset. State is RUN with no div_done afterwards, and imem wait (if_req=1, if_ack=0) gives stall=00001.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stage indices,
// FSM encoding and the per-hazard stall/flush masks.
package pipe_ctrl_pkg;

  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_WB     = 4;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DIV_WAIT  = 2'd1,
    DMEM_WAIT = 2'd2
  } state_t;

  // A hazard freezes every stage up to and including s; the register just
  // downstream of the frozen region takes a bubble.
  function automatic logic [4:0] stall_thru(input int s);
    return 5'((1 << (s + 1)) - 1);
  endfunction

  function automatic logic [4:0] flush_at(input int s);
    return 5'(1 << s);
  endfunction

  localparam logic [4:0] STALL_EXCP = 5'b00000;
  localparam logic [4:0] FLUSH_EXCP = 5'b11110;
  localparam logic [4:0] STALL_DMEM = stall_thru(STG_EX_MEM);
  localparam logic [4:0] FLUSH_DMEM = flush_at(STG_WB);
  localparam logic [4:0] STALL_DIV  = stall_thru(STG_ID_EX);
  localparam logic [4:0] FLUSH_DIV  = flush_at(STG_EX_MEM);
  localparam logic [4:0] STALL_LUSE = stall_thru(STG_IF_ID);
  localparam logic [4:0] FLUSH_LUSE = flush_at(STG_ID_EX);
  localparam logic [4:0] STALL_IMEM = stall_thru(STG_PC);
  localparam logic [4:0] FLUSH_IMEM = flush_at(STG_IF_ID);

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: the ID instruction reads a register that the load
// currently in EX has not yet fetched from memory.
module hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_wd,
  output logic       luse
);

  // $zero is never a real dependency.
  assign luse = ex_mem_read && (ex_wd != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_wd)) ||
                 (id_uses_rt && (id_rt == ex_wd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: resolves exceptions,
// data/instruction bus waits, divide occupancy and load-use hazards.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_wd,
  input  logic        ex_div_start,
  output logic        div_done,
  input  logic        if_req,
  input  logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        mem_abort,
  input  logic        mem_excp,
  input  logic [31:0] excp_target,
  output logic [4:0]  stall,
  output logic [4:0]  flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc
);

  state_t     state, state_nx;
  logic [5:0] div_cnt, cnt_nx;
  logic       div_held, held_nx;
  logic       luse;
  logic       dwait;
  logic       div_due;

  hazard_detect u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_wd       (ex_wd),
    .luse        (luse)
  );

  assign dwait   = mem_req && !mem_ack;
  assign div_due = div_held || (div_cnt == 6'd1);

  always_comb begin
    // NOTE: every output and next-state value gets a default here so no path
    // through the priority chain leaves a latch behind.
    stall       = '0;
    flush       = '0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    div_done    = 1'b0;
    mem_abort   = 1'b0;
    state_nx    = state;
    cnt_nx      = (div_cnt != 6'd0) ? div_cnt - 6'd1 : div_cnt;
    held_nx     = div_held;

    if (rst) begin
      flush = FLUSH_EXCP;
    end else if (mem_excp) begin
      stall       = STALL_EXCP;
      flush       = FLUSH_EXCP;
      pc_redirect = 1'b1;
      redirect_pc = excp_target;
      mem_abort   = (state == DMEM_WAIT) || dwait;
      state_nx    = RUN;
      cnt_nx      = '0;
      held_nx     = 1'b0;
    end else if (state == DMEM_WAIT) begin
      if (dwait) begin
        stall   = STALL_DMEM;
        flush   = FLUSH_DMEM;
        held_nx = div_due;
      end else begin
        div_done = div_due;
        held_nx  = 1'b0;
        state_nx = (div_cnt > 6'd1) ? DIV_WAIT : RUN;
      end
    end else if (dwait) begin
      // The divide counter keeps running underneath the data-bus freeze.
      stall    = STALL_DMEM;
      flush    = FLUSH_DMEM;
      held_nx  = div_due;
      state_nx = DMEM_WAIT;
    end else if (state == DIV_WAIT) begin
      if (div_cnt <= 6'd1) begin
        div_done = 1'b1;
        state_nx = RUN;
      end else begin
        stall = STALL_DIV;
        flush = FLUSH_DIV;
      end
    end else if (ex_div_start) begin
      stall    = STALL_DIV;
      flush    = FLUSH_DIV;
      state_nx = DIV_WAIT;
      cnt_nx   = 6'(DIV_CYCLES - 1);
    end else if (luse) begin
      stall = STALL_LUSE;
      flush = FLUSH_LUSE;
    end else if (if_req && !if_ack) begin
      stall = STALL_IMEM;
      flush = FLUSH_IMEM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      div_cnt  <= '0;
      div_held <= 1'b0;
    end else begin
      state    <= state_nx;
      div_cnt  <= cnt_nx;
      div_held <= held_nx;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: expected output vectors are queued as
// stimulus is applied and compared against the DUT mid-cycle.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_wd;
  logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_div_start;
  logic        if_req, if_ack, mem_req, mem_ack, mem_excp;
  logic [31:0] excp_target;
  logic        div_done, mem_abort, pc_redirect;
  logic [4:0]  stall, flush;
  logic [31:0] redirect_pc;

  typedef struct {
    string       name;
    logic [44:0] v;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_total = 0;
  int   n_pass  = 0;

  localparam logic [4:0]  Z5   = 5'b00000;
  localparam logic [31:0] VEC  = 32'hBFC00380;

  wire [44:0] obs = {stall, flush, pc_redirect, redirect_pc, div_done, mem_abort};

  pipe_ctrl #(.DIV_CYCLES(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_wd       (ex_wd),
    .ex_div_start(ex_div_start),
    .div_done    (div_done),
    .if_req      (if_req),
    .if_ack      (if_ack),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_abort   (mem_abort),
    .mem_excp    (mem_excp),
    .excp_target (excp_target),
    .stall       (stall),
    .flush       (flush),
    .pc_redirect (pc_redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [44:0] vec(input logic [4:0] s, input logic [4:0] f,
                                      input logic pr, input logic [31:0] rp,
                                      input logic dd, input logic ma);
    return {s, f, pr, rp, dd, ma};
  endfunction

  task automatic idle();
    rst = 1'b0; id_rs = '0; id_rt = '0; ex_wd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_div_start = 1'b0;
    if_req = 1'b0; if_ack = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    mem_excp = 1'b0; excp_target = '0;
  endtask

  task automatic push(input string name, input logic [44:0] v);
    exp_t x;
    x.name = name;
    x.v    = v;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; if_req = 1'b1; mem_req = 1'b1; ex_div_start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push($sformatf("reset_out_%0d", k), vec(Z5, 5'b11110, 1'b0, '0, 1'b0, 1'b0));
      @(negedge clk);
      e = exp_q.pop_front(); n_total++;
      if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      else n_pass++;
      tick();
    end
    idle();
    push("after_reset_idle", vec(Z5, Z5, 1'b0, '0, 1'b0, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); n_total++;
    if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    for (int k = 0; k < 6; k++) begin
      idle();
      case (k)
        0: begin ex_mem_read = 1; ex_wd = 5; id_rs = 5; id_uses_rs = 1;
                 push("luse_rs", vec(5'b00011, 5'b00100, 0, '0, 0, 0)); end
        1: begin ex_wd = 5; id_rs = 5; id_uses_rs = 1;
                 push("luse_one_cycle", vec(Z5, Z5, 0, '0, 0, 0)); end
        2: begin ex_mem_read = 1; ex_wd = 0; id_rs = 0; id_uses_rs = 1;
                 push("luse_zero_reg", vec(Z5, Z5, 0, '0, 0, 0)); end
        3: begin ex_mem_read = 1; ex_wd = 9; id_rs = 3; id_rt = 9; id_uses_rt = 1;
                 push("luse_rt", vec(5'b00011, 5'b00100, 0, '0, 0, 0)); end
        4: begin ex_mem_read = 1; ex_wd = 9; id_rs = 3; id_rt = 9;
                 push("luse_rt_unused", vec(Z5, Z5, 0, '0, 0, 0)); end
        default: begin ex_mem_read = 1; ex_wd = 7; id_rs = 7; id_uses_rs = 1; if_req = 1;
                 push("luse_over_imem", vec(5'b00011, 5'b00100, 0, '0, 0, 0)); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front(); n_total++;
      if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_imem_and_fast_ack();
    for (int k = 0; k < 4; k++) begin
      idle();
      case (k)
        0: begin if_req = 1; push("imem_wait", vec(5'b00001, 5'b00010, 0, '0, 0, 0)); end
        1: begin if_req = 1; if_ack = 1; push("imem_ack", vec(Z5, Z5, 0, '0, 0, 0)); end
        2: begin mem_req = 1; mem_ack = 1; push("dmem_same_cycle_ack", vec(Z5, Z5, 0, '0, 0, 0)); end
        default: begin if_req = 1; push("still_run", vec(5'b00001, 5'b00010, 0, '0, 0, 0)); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front(); n_total++;
      if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      else n_pass++;
      tick();
    end
  endtask

  // Divide with an optional data-bus wait spanning cycles [req_lo, ack_at].
  task automatic test_divide(input string tag, input int req_lo, input int ack_at,
                             input int last);
    for (int k = 0; k <= last; k++) begin
      idle();
      ex_div_start = (k == 0);
      if (k == 3) begin ex_mem_read = 1; ex_wd = 4; id_rs = 4; id_uses_rs = 1; end
      if (req_lo >= 0 && k >= req_lo && k <= ack_at) begin
        mem_req = 1; mem_ack = (k == ack_at);
      end
      if (req_lo >= 0 && k >= req_lo && k < ack_at)
        push($sformatf("%s_dmem_k%0d", tag, k), vec(5'b01111, 5'b10000, 0, '0, 0, 0));
      else if (req_lo >= 0 && k == ack_at)
        push($sformatf("%s_ack_k%0d", tag, k), vec(Z5, Z5, 0, '0, ack_at >= 31, 0));
      else if (k <= 30 && !(req_lo >= 0 && ack_at >= 31 && k > ack_at))
        push($sformatf("%s_div_k%0d", tag, k), vec(5'b00111, 5'b01000, 0, '0, 0, 0));
      else if (k == 31 && ack_at < 31)
        push($sformatf("%s_done_k%0d", tag, k), vec(Z5, Z5, 0, '0, 1, 0));
      else
        push($sformatf("%s_idle_k%0d", tag, k), vec(Z5, Z5, 0, '0, 0, 0));
      @(negedge clk);
      e = exp_q.pop_front(); n_total++;
      if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_exception();
    for (int k = 0; k < 7; k++) begin
      idle();
      case (k)
        0: begin mem_req = 1; push("excp_pre_dmem", vec(5'b01111, 5'b10000, 0, '0, 0, 0)); end
        1: begin mem_req = 1; mem_excp = 1; excp_target = VEC;
                 push("excp_in_dmem", vec(Z5, 5'b11110, 1, VEC, 0, 1)); end
        2: begin if_req = 1; push("excp_back_to_run", vec(5'b00001, 5'b00010, 0, '0, 0, 0)); end
        3: begin ex_div_start = 1; mem_excp = 1; excp_target = 32'h8000_0180;
                 push("excp_beats_div", vec(Z5, 5'b11110, 1, 32'h8000_0180, 0, 0)); end
        4: begin push("div_discarded", vec(Z5, Z5, 0, '0, 0, 0)); end
        5: begin mem_req = 1; mem_excp = 1; excp_target = VEC;
                 push("excp_abort_run", vec(Z5, 5'b11110, 1, VEC, 0, 1)); end
        default: begin push("excp_after_idle", vec(Z5, Z5, 0, '0, 0, 0)); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front(); n_total++;
      if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid_div();
    for (int k = 0; k <= 41; k++) begin
      idle();
      ex_div_start = (k == 0);
      if (k == 5 || k == 6) begin
        rst = 1;
        push($sformatf("rst_mid_k%0d", k), vec(Z5, 5'b11110, 0, '0, 0, 0));
      end else if (k < 5) begin
        push($sformatf("rst_pre_div_k%0d", k), vec(5'b00111, 5'b01000, 0, '0, 0, 0));
      end else if (k == 41) begin
        if_req = 1;
        push("rst_then_imem", vec(5'b00001, 5'b00010, 0, '0, 0, 0));
      end else begin
        push($sformatf("rst_no_done_k%0d", k), vec(Z5, Z5, 0, '0, 0, 0));
      end
      @(negedge clk);
      e = exp_q.pop_front(); n_total++;
      if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    test_reset();
    test_load_use();
    test_imem_and_fast_ack();
    test_divide("div", -1, -1, 32);
    test_divide("div_dmem", 5, 10, 32);
    test_divide("div_held", 5, 35, 37);
    test_exception();
    test_reset_mid_div();
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
